// File: rtl/uart_prog_loader_if.sv
// Bus bundle between the UART program loader and its host / program memory.
// Optional macro: UART_PARITY_EN adds the sticky parity-error flag pe.
interface uart_prog_loader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              load;
    logic              rx;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              fe;
    logic              busy;
    logic              full;
    logic              done;
    logic [ADDR_W:0]   count;
`ifdef UART_PARITY_EN
    logic              pe;
`endif

    // Host side: drives the loading window and the serial line.
    modport master (
        output load, rx,
        input  wr_en, wr_addr, wr_data, fe, busy, full, done, count
`ifdef UART_PARITY_EN
        , input pe
`endif
    );

    // Loader side.
    modport slave (
        input  load, rx,
        output wr_en, wr_addr, wr_data, fe, busy, full, done, count
`ifdef UART_PARITY_EN
        , output pe
`endif
    );
endinterface

// File: rtl/uart_prog_loader.sv
// UART program loader: receives 8N1-style frames (start + DATA_W + stop)
// while the load window is open and writes each word sequentially into a
// 2**ADDR_W-word program memory.
// Optional macro: UART_PARITY_EN inserts an even-parity bit before the stop
// bit and drives the sticky parity-error flag on the bus.
module uart_prog_loader #(
    parameter int BAUDRATE = 24,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    uart_prog_loader_if.slave bus
);
    localparam int unsigned HALF = BAUDRATE / 2;
    localparam int unsigned BCW  = $clog2(BAUDRATE);
    localparam int unsigned NCW  = $clog2(DATA_W + 1);

    localparam logic [BCW-1:0]    HALF_M1   = BCW'(HALF - 1);
    localparam logic [BCW-1:0]    BAUD_M1   = BCW'(BAUDRATE - 1);
    localparam logic [NCW-1:0]    LAST_BIT  = NCW'(DATA_W - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WRITE} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WRITE} state_t;
`endif

    state_t state_q, state_d;

    logic              rx_meta, rx_sync, rx_prev;
    logic              load_q;
    logic [BCW-1:0]    baud_cnt;
    logic [NCW-1:0]    bit_cnt;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W:0]   count_q;
    logic              full_q, fe_q, done_q;
`ifdef UART_PARITY_EN
    logic              perr_q, pe_q;
    logic              par_bad;
`endif

    logic rx_fall, load_rise, load_fall;
    logic sampling, tick, do_write;

    assign rx_fall   = rx_prev & ~rx_sync;
    assign load_rise = bus.load & ~load_q;
    assign load_fall = ~bus.load & load_q;
    assign sampling  = (state_q != IDLE) && (state_q != WRITE);
    // The start bit is checked half a bit period in; every later bit one full period on.
    assign tick      = (state_q == START) ? (baud_cnt == HALF_M1) : (baud_cnt == BAUD_M1);

`ifdef UART_PARITY_EN
    assign par_bad  = (^shift_q) ^ rx_sync;
    assign do_write = (state_q == WRITE) && !load_fall && !full_q && !perr_q;
`else
    assign do_write = (state_q == WRITE) && !load_fall && !full_q;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; a falling load edge aborts whatever frame is in flight.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (bus.load && rx_fall) state_d = START;
            START:  if (tick) state_d = rx_sync ? IDLE : DATA;
`ifdef UART_PARITY_EN
            DATA:   if (tick && bit_cnt == LAST_BIT) state_d = PARITY;
            PARITY: if (tick) state_d = STOP;
`else
            DATA:   if (tick && bit_cnt == LAST_BIT) state_d = STOP;
`endif
            STOP:   if (tick) state_d = rx_sync ? WRITE : IDLE;
            WRITE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (load_fall) state_d = IDLE;
    end

    // Synchroniser, bit timing, shift register, write pointer and status flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            load_q    <= 1'b0;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_q   <= '0;
            wr_data_q <= '0;
            ptr_q     <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            fe_q      <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_PARITY_EN
            perr_q    <= 1'b0;
            pe_q      <= 1'b0;
`endif
        end else begin
            rx_meta <= bus.rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            load_q  <= bus.load;
            done_q  <= load_fall;

            if (sampling && !tick && state_d == state_q) baud_cnt <= baud_cnt + 1'b1;
            else                                         baud_cnt <= '0;

            if (state_q == DATA) begin
                if (tick) begin
                    bit_cnt <= bit_cnt + 1'b1;
                    shift_q <= {rx_sync, shift_q[DATA_W-1:1]};
                end
            end else begin
                bit_cnt <= '0;
            end

`ifdef UART_PARITY_EN
            if (state_q == START) perr_q <= 1'b0;
            if (state_q == PARITY && tick && !load_fall) begin
                perr_q <= par_bad;
                if (par_bad) pe_q <= 1'b1;
            end
            if (state_q == STOP && tick && !load_fall) begin
                if (!rx_sync)     fe_q      <= 1'b1;
                else if (!perr_q) wr_data_q <= shift_q;
            end
`else
            if (state_q == STOP && tick && !load_fall) begin
                if (!rx_sync) fe_q      <= 1'b1;
                else          wr_data_q <= shift_q;
            end
`endif

            // The pointer parks on the last address once it has been written.
            if (do_write) begin
                count_q <= count_q + 1'b1;
                if (ptr_q == LAST_ADDR) full_q <= 1'b1;
                else                    ptr_q  <= ptr_q + 1'b1;
            end

            if (load_rise) begin
                ptr_q   <= '0;
                count_q <= '0;
                full_q  <= 1'b0;
                fe_q    <= 1'b0;
`ifdef UART_PARITY_EN
                pe_q    <= 1'b0;
`endif
            end
        end
    end

    assign bus.wr_en   = do_write;
    assign bus.wr_addr = ptr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.fe      = fe_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.full    = full_q;
    assign bus.done    = done_q;
    assign bus.count   = count_q;
`ifdef UART_PARITY_EN
    assign bus.pe      = pe_q;
`endif
endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: frames are driven bit by bit, a
// queue of expected memory writes is built from the frame contents, and a
// negedge monitor checks every write strobe against it.
module tb_uart_prog_loader;
    localparam int BAUD  = 24;
    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    uart_prog_loader_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    uart_prog_loader #(.BAUDRATE(BAUD), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t e_w;
    int  checks = 0;
    int  errors = 0;
    int  exp_count = 0;
    int  exp_done = 0;
    int  done_seen = 0;
    bit  exp_fe = 0;
    bit  exp_pe = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [11:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            bus.rx = bits[i];
            cyc(BAUD);
        end
    endtask

    // Expected effect is recorded before the frame goes out, so the monitor
    // already holds it when the strobe appears.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok);
        logic [11:0] f;
        int n;
        if (bus.load) begin
            if (!stop_ok) exp_fe = 1;
`ifdef UART_PARITY_EN
            else if (!par_ok) exp_pe = 1;
`endif
            else if (exp_count < DEPTH) begin
                exp_q.push_back('{addr: AW'(exp_count), data: d});
                exp_count++;
            end
        end
`ifdef UART_PARITY_EN
        f = {1'b0, stop_ok, (^d) ^ !par_ok, d, 1'b0};
        n = 11;
`else
        f = {2'b00, par_ok, stop_ok, d, 1'b0};
        n = 10;
`endif
        send_bits(f, n);
        bus.rx = 1'b1;
        cyc(BAUD);
    endtask

    task automatic quiet(input string name);
        cyc(4);
        chk({name, "_pending"}, exp_q.size(), 0);
        chk({name, "_count"}, bus.count, exp_count);
        chk({name, "_fe"}, bus.fe, exp_fe);
        chk({name, "_full"}, bus.full, (exp_count == DEPTH));
        chk({name, "_busy"}, bus.busy, 0);
        chk({name, "_done"}, done_seen, exp_done);
`ifdef UART_PARITY_EN
        chk({name, "_pe"}, bus.pe, exp_pe);
`endif
    endtask

    task automatic clear_model();
        exp_count = 0;
        exp_fe = 0;
        exp_pe = 0;
    endtask

    // Every write strobe must match the head of the expected-write queue.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.wr_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual addr=%0d data=%0h required=no write",
                             bus.wr_addr, bus.wr_data);
                end else begin
                    e_w = exp_q.pop_front();
                    chk("write", {bus.wr_addr, bus.wr_data}, {e_w.addr, e_w.data});
                end
            end
            if (bus.done) done_seen++;
        end
    end

    logic [7:0] basic [6] = '{8'hC0, 8'h40, 8'hA3, 8'hE5, 8'hA0, 8'h00};

    initial begin
        bus.load = 1'b0;
        bus.rx   = 1'b1;
        reset    = 1'b0;
        cyc(5);
        chk("rst_count", bus.count, 0);
        chk("rst_addr", bus.wr_addr, 0);
        chk("rst_data", bus.wr_data, 0);
        chk("rst_flags", {bus.wr_en, bus.fe, bus.busy, bus.full, bus.done}, 0);
        reset = 1'b1;
        cyc(3);

        // Basic loading window.
        bus.load = 1'b1;
        cyc(3);
        foreach (basic[i]) send_frame(basic[i], 1'b1, 1'b1);
        quiet("basic");
        chk("basic_count_lit", bus.count, 6);
        chk("basic_addr_lit", bus.wr_addr, 6);
        chk("basic_data_lit", bus.wr_data, 8'h00);

        // Short low glitch is a false start.
        bus.rx = 1'b0;
        cyc(8);
        bus.rx = 1'b1;
        cyc(2);
        chk("glitch_busy", bus.busy, 1);
        cyc(BAUD);
        quiet("glitch");
        chk("glitch_fe_lit", bus.fe, 0);

        // Bad stop bit.
        send_frame(8'h55, 1'b0, 1'b1);
        quiet("stop_err");
        chk("stop_err_fe_lit", bus.fe, 1);
        chk("stop_err_count_lit", bus.count, 6);
        chk("stop_err_hold_lit", bus.wr_data, 8'h00);

        // Close window; traffic with load low is ignored.
        bus.load = 1'b0;
        exp_done++;
        cyc(3);
        send_frame(8'h5A, 1'b1, 1'b1);
        quiet("load_off");
        chk("load_off_data_lit", bus.wr_data, 8'h00);

        // Reopen: pointer, count and FE clear.
        bus.load = 1'b1;
        clear_model();
        cyc(3);
        quiet("reload");
        chk("reload_fe_lit", bus.fe, 0);
        chk("reload_addr_lit", bus.wr_addr, 0);

        // Fill the memory and send one extra frame.
        for (int i = 0; i < 33; i++) begin
            send_frame(8'(i * 37 + 11), 1'b1, 1'b1);
            if (i == 30) begin
                chk("fill31_full_lit", bus.full, 0);
                chk("fill31_count_lit", bus.count, 31);
            end
        end
        quiet("fill");
        chk("fill_full_lit", bus.full, 1);
        chk("fill_count_lit", bus.count, 32);
        chk("fill_addr_lit", bus.wr_addr, 31);
        chk("fill_data_lit", bus.wr_data, 8'hAB);

        // Load falls in the middle of a data bit.
        bus.load = 1'b0;
        exp_done++;
        cyc(3);
        bus.load = 1'b1;
        clear_model();
        cyc(3);
        send_bits(12'h00A, 4);
        bus.rx = 1'b0;
        cyc(10);
        bus.load = 1'b0;
        exp_done++;
        cyc(2);
        bus.rx = 1'b1;
        cyc(BAUD * 8);
        quiet("load_abort");

        // Reset in the middle of a frame.
        bus.load = 1'b1;
        cyc(3);
        send_bits(12'h00A, 4);
        cyc(5);
        reset = 1'b0;
        cyc(1);
        chk("midrst_count", bus.count, 0);
        chk("midrst_addr", bus.wr_addr, 0);
        chk("midrst_data", bus.wr_data, 0);
        chk("midrst_flags", {bus.wr_en, bus.fe, bus.busy, bus.full, bus.done}, 0);
        bus.rx = 1'b1;
        reset  = 1'b1;
        clear_model();
        cyc(BAUD * 8);
        quiet("midrst");
        send_frame(8'h3C, 1'b1, 1'b1);
        quiet("post_reset");
        chk("post_reset_addr_lit", bus.wr_addr, 1);
        chk("post_reset_data_lit", bus.wr_data, 8'h3C);

`ifdef UART_PARITY_EN
        send_frame(8'hA3, 1'b1, 1'b1);
        send_frame(8'hA3, 1'b1, 1'b0);
        quiet("parity");
        chk("parity_pe_lit", bus.pe, 1);
        chk("parity_count_lit", bus.count, 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_prog_loader.md
UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 Parameter BAUDRATE, default 24, clocks per UART bit period (SHALL be >= 4).
REQ-002 Parameter DATA_W, default 8, data bits per frame and width of each program word.
REQ-003 Parameter ADDR_W, default 5, program-memory address width; depth is 2**ADDR_W words.
REQ-004 Clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 Reset  input  1  synchronous, active-low reset.
REQ-006 Load  input  1  loading window enable.
REQ-007 RX  input  1  asynchronous UART line; idle high.
REQ-008 Wr_en  output  1  one-cycle write strobe to program memory.
REQ-009 Wr_addr  output  ADDR_W  write address.
REQ-010 Wr_data  output  DATA_W  received word.
REQ-011 FE  output  1  sticky frame error.
REQ-012 Busy  output  1  high while a frame is in progress.
REQ-013 Full  output  1  high once all memory words are written.
REQ-014 Done  output  1  one-cycle pulse at the end of the loading window.
REQ-015 Count  output  ADDR_W+1  number of words written in the current window.

Function
REQ-016 RX SHALL pass through a 2-flop synchroniser; all sampling SHALL use the synchronised value.
REQ-017 FSM states: IDLE, START, DATA, PARITY (macro only), STOP, WRITE.
REQ-018 IDLE -> START on a synchronised RX high-to-low transition while Load=1.
REQ-019 START: after BAUDRATE/2 clocks, sample RX; low -> DATA; high -> IDLE (false start, no FE).
REQ-020 DATA: sample every BAUDRATE clocks; DATA_W bits, LSB first, shifted into Wr_data.
REQ-021 STOP: sample BAUDRATE clocks after the last data bit; high -> WRITE; low -> FE=1, frame discarded, -> IDLE.
REQ-022 WRITE: lasts exactly 1 cycle; Wr_en=1 with Wr_addr=pointer unless Full; then pointer+1 and Count+1; -> IDLE.
REQ-023 Write latency: Wr_en SHALL assert on the clock after the stop-bit sample.
REQ-024 After the write to address 2**ADDR_W-1: Full=1, pointer stays and does not wrap; later valid frames are received but not written, and Count is unchanged.
REQ-025 Load 0->1 edge: pointer, Count, Full and FE SHALL clear to 0.
REQ-026 Load 1->0 edge: Done=1 for one cycle; an in-progress frame is aborted with no write; -> IDLE.
REQ-027 Busy=1 in every state except IDLE.
REQ-028 Wr_data SHALL hold the last received word between frames.
REQ-029 Load=0 in IDLE: RX activity SHALL be ignored.

Reset
REQ-030 Reset=0 at a rising Clk edge: state=IDLE, bit and baud counters=0, Wr_en=0, Wr_addr=0, Wr_data=0, FE=0, Busy=0, Full=0, Done=0, Count=0, synchroniser flops=1.
REQ-031 Reset mid-frame SHALL abort the frame with no write and no FE.
REQ-032 Reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-033 Macro UART_PARITY_EN defined: an even-parity bit follows the data bits (PARITY state, 1 bit period); output PE (1 bit, sticky, cleared like FE) SHALL set on a mismatch, and the word SHALL not be written; STOP checking is unchanged.
REQ-034 Macro UART_PARITY_EN undefined: no PARITY state, no PE port, and the frame is start + DATA_W + stop.

Verification (BAUDRATE=24, DATA_W=8, ADDR_W=5, macro off unless stated)
REQ-035 Load=1; frames C0,40,A3,E5,A0,00 -> Wr_en pulses with (addr,data) = (0,C0),(1,40),(2,A3),(3,E5),(4,A0),(5,00); Count=6; FE=0.
REQ-036 Frame 55 with stop bit low -> FE=1, no Wr_en, Count unchanged; next Load rising edge -> FE=0.
REQ-037 RX low glitch of 8 clocks -> returns to IDLE, no FE, no write.
REQ-038 33 valid frames -> 32 writes, Full=1 after the write to address 31, 33rd frame not written, Count=32.
REQ-039 Load falls mid-data-bit, then Reset=0 mid-frame in a second run -> no write in either case; Done pulses once for the Load fall; all outputs at reset values after Reset.
REQ-040 UART_PARITY_EN: frame A3 with parity 0 -> written; frame A3 with parity 1 -> PE=1, no write.
